led_cpu_step_ctrl: RTL and testbench
====================================

# led_cpu_step_ctrl

Execution-pacing controller for the LED CPU. Consumes the one-cycle `tick` pulse from the shared tick generator and decides when the CPU may execute its next instruction: free-running at a programmable tick ratio, single-stepped from a push-button, or halted. It talks to the CPU through a req/ack handshake, counts completed steps, and flags overruns when the CPU cannot keep up with the selected rate.

## Interface
- `SPD_W`, default 4: width of `speed`.
- `CNT_W`, default 16: width of `step_cnt`.

- `mclk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-`mclk` pulse from the tick generator.
- `mode` in 2: 00 HALT, 01 RUN, 10 STEP, 11 reserved (behaves as HALT).
- `speed` in SPD_W: RUN issues one step per `speed`+1 ticks.
- `step_btn` in 1: raw asynchronous button level.
- `clr_ovr` in 1: synchronous clear of `overrun`.
- `step_ack` in 1: CPU pulse, instruction finished.
- `step_req` out 1: registered request to the CPU; held until acknowledged.
- `busy` out 1: high while in REQ (equals `step_req`).
- `step_cnt` out CNT_W: completed handshakes; wraps modulo 2^CNT_W.
- `overrun` out 1: sticky; a tick arrived in REQ while in RUN.

## Operation
- States IDLE and REQ. Reset: IDLE; `step_req`=0, `busy`=0, `step_cnt`=0, `overrun`=0; tick counter 0; button synchroniser and edge register 0.
- Button path: 2-flop synchroniser followed by a rising-edge detector. The edge pulse is 1 cycle wide, 3 cycles after the level rises.
- IDLE, RUN: each `tick` increments the tick counter. On a `tick` with counter == `speed`, clear the counter and go to REQ. With `speed`=0, every tick steps.
- IDLE, STEP: a button edge goes to REQ. Ticks are ignored and the counter is held at 0.
- IDLE, HALT or reserved: remain in IDLE with the counter held at 0.
- A `mode` change seen in IDLE clears the tick counter in that cycle.
- REQ: hold `step_req`=1. On `step_ack`=1, return to IDLE and increment `step_cnt`.
- An ongoing handshake is never abandoned. A `mode` change to HALT during REQ waits for the ack.
- In REQ, the tick counter is held at 0 and button edges are dropped, not queued. In RUN, a tick in REQ sets `overrun`. This includes a tick in the same cycle as the ack.
- `step_ack` while in IDLE is ignored, with no count change.
- `clr_ovr` clears `overrun`. If `clr_ovr` and an overrun-setting tick occur in the same cycle, set wins.
- `speed` is sampled live. If `speed` drops below the current counter value, the counter counts up and wraps to 0 at 2^SPD_W, then reaches the new `speed`. There is no early trigger.

## Timing
- The cycle after the qualifying tick or button edge has `step_req`=1. Latency is 1 cycle from tick, or 4 cycles from the button level.
- `step_ack` sampled high in cycle N gives, in cycle N+1: `step_req`=0 and `step_cnt` incremented.
- After an ack, at least 1 IDLE cycle precedes the next request.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `rst` asserted mid-handshake drops `step_req` immediately (asynchronously). The CPU must tolerate a lost request.

## Structure
- Shared package (`led_cpu_pkg`): mode encodings `MODE_HALT`/`MODE_RUN`/`MODE_STEP`, state encodings `ST_IDLE`/`ST_REQ`.
- One sub-module: `btn_edge_sync`, the 2-flop synchroniser plus rising-edge detector. It resets asynchronously on `rst` and is reused for other front-panel buttons.
- The FSM, tick counter, step counter and overrun flag all stay in this module.

## Test plan
- RUN, `speed`=3, CPU acks 2 cycles after req. Apply 16 ticks spaced 20 cycles apart -> exactly 4 requests, one on the cycle after ticks 4, 8, 12 and 16. Final `step_cnt`=4 and `overrun`=0.
- RUN, `speed`=0, ack withheld for 50 cycles, ticks every 10 cycles -> a single request held, then `overrun`=1. After the ack, `step_cnt`=1. Pulsing `clr_ovr` with no tick present -> `overrun`=0.
- STEP, 3 button presses of 10 cycles each, spaced 30 cycles apart, with immediate ack -> 3 requests, each 4 cycles after its rise; `step_cnt`=3. A press made while in REQ produces no extra request.
- Mode switched RUN -> HALT while in REQ -> `step_req` stays 1 until the ack. Afterwards, 10 ticks produce no requests and the counter stays at 0.
- `step_cnt` preset near wrap (CNT_W=4), 17 acked steps -> wraps to 1. A stray `step_ack` in IDLE leaves the count unchanged.
- `rst` pulsed asynchronously while `step_req`=1 and `overrun`=1 -> all outputs drop to 0 before the next `mclk` edge, and the block resumes from IDLE.

Source files
------------

// File: rtl/led_cpu_pkg.sv
// Shared encodings for the LED CPU front-panel and pacing logic.
package led_cpu_pkg;

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_STEP = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/led_cpu_step_ctrl_if.sv
// Step request/acknowledge handshake between the pacing controller and the CPU.
interface led_cpu_step_ctrl_if;

    logic step_req;
    logic step_ack;

    modport master (output step_req, input step_ack);
    modport slave  (input step_req, output step_ack);

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for a raw push-button level plus a registered rising-edge pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic dly_p2;
    logic rise_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            dly_p2  <= 1'b0;
            rise_p2 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            // stage p2: edge detect on the synchronised level
            dly_p2  <= sync_p1;
            rise_p2 <= sync_p1 & ~dly_p2;
        end
    end

    assign rise = rise_p2;

endmodule

// File: rtl/led_cpu_step_ctrl.sv
// Paces LED CPU instruction execution: free-run on a tick ratio, single-step
// from a button, or halt; counts completed handshakes and flags overruns.
module led_cpu_step_ctrl
    import led_cpu_pkg::*;
#(
    parameter int SPD_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [1:0]            mode,
    input  logic [SPD_W-1:0]      speed,
    input  logic                  step_btn,
    input  logic                  clr_ovr,
    led_cpu_step_ctrl_if.master   cpu,
    output logic                  busy,
    output logic [CNT_W-1:0]      step_cnt,
    output logic                  overrun
);

    state_e             state_q;
    state_e             state_d;
    mode_e              mode_c;
    logic [1:0]         mode_q;
    logic [SPD_W-1:0]   tick_cnt;
    logic               btn_rise;
    logic               run;
    logic               stepm;
    logic               mode_chg;
    logic               in_req;

    btn_edge_sync u_btn (
        .clk  (mclk),
        .rst  (rst),
        .btn  (step_btn),
        .rise (btn_rise)
    );

    assign mode_c   = mode_e'(mode);
    assign run      = (mode_c == MODE_RUN);
    assign stepm    = (mode_c == MODE_STEP);
    assign mode_chg = (mode != mode_q);
    assign in_req   = (state_q == ST_REQ);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // A mode change seen in IDLE swallows that cycle's tick; button edges still count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run && !mode_chg && tick && (tick_cnt == speed))
                    state_d = ST_REQ;
                else if (stepm && btn_rise)
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (cpu.step_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            mode_q   <= 2'b00;
            tick_cnt <= '0;
            step_cnt <= '0;
            overrun  <= 1'b0;
        end else begin
            mode_q <= mode;
            // Counter wraps naturally at 2^SPD_W when speed drops below it.
            if (!in_req && run && !mode_chg) begin
                if (tick) tick_cnt <= (tick_cnt == speed) ? '0 : tick_cnt + 1'b1;
            end else begin
                tick_cnt <= '0;
            end
            if (in_req && cpu.step_ack) step_cnt <= step_cnt + 1'b1;
            if (in_req && run && tick) overrun <= 1'b1;
            else if (clr_ovr)          overrun <= 1'b0;
        end
    end

    assign cpu.step_req = in_req;
    assign busy         = in_req;

endmodule

// File: tb/tb_led_cpu_step_ctrl.sv
// Directed bench for led_cpu_step_ctrl with a simple CPU ack responder in the cycle task.
module tb_led_cpu_step_ctrl;

    localparam int SPD_W = 4;
    localparam int CNT_W = 4;

    logic             mclk = 1'b0;
    logic             rst = 1'b0;
    logic             tick = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [SPD_W-1:0] speed = '0;
    logic             step_btn = 1'b0;
    logic             clr_ovr = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] step_cnt;
    logic             overrun;

    led_cpu_step_ctrl_if cpu_if ();

    led_cpu_step_ctrl #(.SPD_W(SPD_W), .CNT_W(CNT_W)) dut (
        .mclk     (mclk),
        .rst      (rst),
        .tick     (tick),
        .mode     (mode),
        .speed    (speed),
        .step_btn (step_btn),
        .clr_ovr  (clr_ovr),
        .cpu      (cpu_if.master),
        .busy     (busy),
        .step_cnt (step_cnt),
        .overrun  (overrun)
    );

    always #5 mclk = ~mclk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;
    int req_rises = 0;
    int last_rise = -1;
    int ack_cd = 0;
    int ack_dly = 1;
    int base;
    int c0;
    bit auto_ack = 0;
    bit prev_req = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: advance to just after the edge, then run the CPU model.
    task automatic clk1();
        @(posedge mclk);
        #1;
        cyc_n++;
        if (cpu_if.step_req === 1'b1 && !prev_req) begin
            req_rises++;
            last_rise = cyc_n;
            ack_cd = ack_dly;
        end
        prev_req = (cpu_if.step_req === 1'b1);
        if (auto_ack) begin
            cpu_if.step_ack = 1'b0;
            if (cpu_if.step_req === 1'b1) begin
                if (ack_cd <= 1) cpu_if.step_ack = 1'b1;
                else ack_cd--;
            end
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    task automatic man_ack();
        cpu_if.step_ack = 1'b1;
        clk1();
        cpu_if.step_ack = 1'b0;
    endtask

    initial begin
        cpu_if.step_ack = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_req", cpu_if.step_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", step_cnt, 0);
        chk("rst_ovr", overrun, 0);
        clk1();
        clk1();
        rst = 1'b0;
        clk1();

        // RUN, speed 3, ack two cycles after request
        mode = 2'b01; speed = 4'd3; auto_ack = 1; ack_dly = 2;
        clk1();
        for (int i = 1; i <= 16; i++) begin
            do_tick();
            chk($sformatf("run3_t%0d", i), cpu_if.step_req, (i % 4 == 0) ? 1 : 0);
            if (i % 4 == 0) chk($sformatf("run3_lat%0d", i), last_rise, cyc_n);
            repeat (19) clk1();
        end
        chk("run3_rises", req_rises, 4);
        chk("run3_cnt", step_cnt, 4);
        chk("run3_ovr", overrun, 0);

        // RUN, speed 0, ack withheld: overrun then clear
        speed = 4'd0; auto_ack = 0; base = req_rises;
        clk1();
        do_tick();
        chk("ovr_req0", cpu_if.step_req, 1);
        chk("ovr_ovr0", overrun, 0);
        for (int i = 0; i < 4; i++) begin
            repeat (9) clk1();
            do_tick();
            chk("ovr_hold", cpu_if.step_req, 1);
        end
        chk("ovr_set", overrun, 1);
        chk("ovr_rises", req_rises, base + 1);
        man_ack();
        chk("ovr_ackreq", cpu_if.step_req, 0);
        chk("ovr_cnt", step_cnt, 5);
        chk("ovr_sticky", overrun, 1);
        clr_ovr = 1'b1; clk1(); clr_ovr = 1'b0;
        chk("ovr_clr", overrun, 0);

        // tick + ack + clr_ovr in the same cycle: set wins, ack completes
        do_tick();
        chk("sw_req", cpu_if.step_req, 1);
        tick = 1'b1; cpu_if.step_ack = 1'b1; clr_ovr = 1'b1;
        clk1();
        tick = 1'b0; cpu_if.step_ack = 1'b0; clr_ovr = 1'b0;
        chk("sw_req_drop", cpu_if.step_req, 0);
        chk("sw_ovr", overrun, 1);
        chk("sw_cnt", step_cnt, 6);
        clr_ovr = 1'b1; clk1(); clr_ovr = 1'b0;
        chk("sw_clr", overrun, 0);

        // speed dropped below counter: count up, wrap, then hit the new speed
        speed = 4'd5; clk1();
        do_tick(); clk1(); do_tick(); clk1(); do_tick(); clk1();
        chk("live_cnt3", dut.tick_cnt, 3);
        speed = 4'd1;
        for (int i = 1; i <= 15; i++) begin
            do_tick();
            chk($sformatf("live_t%0d", i), cpu_if.step_req, (i == 15) ? 1 : 0);
            clk1();
        end
        man_ack();
        chk("live_cnt", step_cnt, 7);

        // STEP mode: three presses, immediate ack, ticks ignored
        mode = 2'b10; auto_ack = 1; ack_dly = 1; base = req_rises;
        clk1();
        for (int i = 1; i <= 3; i++) begin
            step_btn = 1'b1; c0 = cyc_n;
            repeat (10) clk1();
            step_btn = 1'b0;
            chk($sformatf("step_lat%0d", i), last_rise - c0, 4);
            chk($sformatf("step_rises%0d", i), req_rises, base + i);
            do_tick();
            repeat (19) clk1();
        end
        chk("step_cnt", step_cnt, 10);

        // press while already in REQ is dropped
        auto_ack = 0; base = req_rises;
        step_btn = 1'b1; repeat (10) clk1();
        step_btn = 1'b0; repeat (5) clk1();
        step_btn = 1'b1; repeat (10) clk1();
        step_btn = 1'b0; repeat (10) clk1();
        chk("drop_req", cpu_if.step_req, 1);
        chk("drop_rises", req_rises, base + 1);
        man_ack();
        repeat (20) clk1();
        chk("drop_idle", cpu_if.step_req, 0);
        chk("drop_rises2", req_rises, base + 1);
        chk("drop_cnt", step_cnt, 11);

        // RUN -> HALT during REQ: request held until ack, then nothing
        mode = 2'b01; speed = 4'd0; clk1();
        do_tick();
        chk("halt_req", cpu_if.step_req, 1);
        mode = 2'b00;
        repeat (5) clk1();
        do_tick();
        chk("halt_hold", cpu_if.step_req, 1);
        chk("halt_noovr", overrun, 0);
        man_ack();
        chk("halt_ackreq", cpu_if.step_req, 0);
        chk("halt_cnt", step_cnt, 12);
        base = req_rises;
        for (int i = 0; i < 10; i++) begin
            do_tick();
            clk1(); clk1();
        end
        chk("halt_norise", req_rises, base);
        chk("halt_tcnt", dut.tick_cnt, 0);

        // step_cnt wrap with CNT_W=4: 17 steps from reset lands on 1
        rst = 1'b1; clk1(); clk1(); rst = 1'b0;
        chk("wrap_rst", step_cnt, 0);
        mode = 2'b01; speed = 4'd0; auto_ack = 1; ack_dly = 1;
        clk1();
        for (int i = 1; i <= 17; i++) begin
            do_tick();
            repeat (3) clk1();
            if (i == 16) chk("wrap_zero", step_cnt, 0);
        end
        chk("wrap_one", step_cnt, 1);
        auto_ack = 0;
        man_ack();
        chk("stray_cnt", step_cnt, 1);
        chk("stray_req", cpu_if.step_req, 0);

        // asynchronous reset mid-handshake with overrun set
        do_tick();
        do_tick();
        chk("ar_req_pre", cpu_if.step_req, 1);
        chk("ar_ovr_pre", overrun, 1);
        #3 rst = 1'b1;
        #1;
        chk("ar_req", cpu_if.step_req, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ovr", overrun, 0);
        chk("ar_cnt", step_cnt, 0);
        rst = 1'b0;
        clk1();
        chk("ar_idle", cpu_if.step_req, 0);
        do_tick();
        chk("ar_resume", cpu_if.step_req, 1);
        man_ack();
        chk("ar_resume_cnt", step_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
